// File: rtl/mul_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_eval_pkg
//  Description : Shared types and helpers for the multiplier error evaluator.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eval_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_abs_diff.sv
`default_nettype none
// ============================================================================
//  Module      : mul_abs_diff
//  Description : Combinational unsigned absolute difference |a - b|.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_abs_diff #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = (a >= b) ? (a - b) : (b - a);

endmodule
`default_nettype wire

// File: rtl/mul_error_accum.sv
`default_nettype none
// ============================================================================
//  Module      : mul_error_accum
//  Description : Windowed error-distance statistics for an approximate
//                multiplier: 3-stage pipeline (capture, ED, accumulate).
//  Revision    : 1.0  initial release
// ============================================================================
module mul_error_accum
    import mul_eval_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  SAMPLES = 256,
    parameter int  ACC_W   = 32,
    localparam int CNT_W   = $clog2(SAMPLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [2*WIDTH-1:0]   approx_prod,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     sum_ed,
    output logic                 sum_sat,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     sample_count
);

    localparam int               c_PW      = 2 * WIDTH;
    localparam int               c_SUM_W   = max_int(ACC_W, c_PW) + 1;
    localparam logic [ACC_W-1:0] c_ACC_MAX = '1;
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(SAMPLES - 1);

    eval_state_t        r_state;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_PW-1:0]    r_approx;
    logic               r_v1;

    logic [c_PW-1:0]    r_ed;
    logic               r_nz;
    logic               r_v2;

    logic [ACC_W-1:0]   r_sum_ed;
    logic               r_sum_sat;
    logic [c_PW-1:0]    r_max_ed;
    logic [CNT_W-1:0]   r_err_count;
    logic [CNT_W-1:0]   r_sample_count;

    logic               w_accept;
    logic [c_PW-1:0]    w_exact;
    logic [c_PW-1:0]    w_ed;
    logic [c_SUM_W-1:0] w_sum_full;
    logic               w_sum_ovf;

    assign w_accept = in_valid & r_in_ready;
    assign w_exact  = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    mul_abs_diff #(
        .W (c_PW)
    ) u_abs_diff (
        .a (w_exact),
        .b (r_approx),
        .y (w_ed)
    );

    // The sum is formed one bit wider than either operand so a clamp is
    // visible even when ACC_W is narrower than the product width.
    assign w_sum_full = c_SUM_W'(r_sum_ed) + c_SUM_W'(r_ed);
    assign w_sum_ovf  = |w_sum_full[c_SUM_W-1:ACC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a      <= in1;
                r_b      <= in2;
                r_approx <= approx_prod;
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_ed <= w_ed;
                r_nz <= |w_ed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_in_ready     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sum_ed       <= '0;
            r_sum_sat      <= 1'b0;
            r_max_ed       <= '0;
            r_err_count    <= '0;
            r_sample_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_v2) begin
                r_sum_ed    <= w_sum_ovf ? c_ACC_MAX : w_sum_full[ACC_W-1:0];
                r_sum_sat   <= r_sum_sat | w_sum_ovf;
                r_err_count <= r_err_count + CNT_W'(r_nz);
                if (r_ed > r_max_ed) begin
                    r_max_ed <= r_ed;
                end
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state        <= RUN;
                        r_in_ready     <= 1'b1;
                        r_busy         <= 1'b1;
                        r_sum_ed       <= '0;
                        r_sum_sat      <= 1'b0;
                        r_max_ed       <= '0;
                        r_err_count    <= '0;
                        r_sample_count <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_sample_count <= r_sample_count + 1'b1;
                        if (r_sample_count == c_LAST) begin
                            r_state    <= DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!r_v1 && !r_v2) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign sum_ed       = r_sum_ed;
    assign sum_sat      = r_sum_sat;
    assign max_ed       = r_max_ed;
    assign err_count    = r_err_count;
    assign sample_count = r_sample_count;

endmodule
`default_nettype wire

// File: tb/tb_mul_error_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_error_accum
//  Description : Self-checking bench; two instances (ACC_W 32 and 8) share
//                stimulus and are compared every cycle with a window model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_error_accum;

    localparam int c_SAMPLES = 4;
    localparam int c_IDLE = 0, c_RUN = 1, c_DRAIN = 2, c_DONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in1 = '0;
    logic [7:0]  in2 = '0;
    logic [15:0] approx_prod = '0;

    logic        a_in_ready, a_busy, a_done, a_sum_sat;
    logic [31:0] a_sum_ed;
    logic [15:0] a_max_ed;
    logic [2:0]  a_err_count, a_sample_count;
    logic        s_in_ready, s_busy, s_done, s_sum_sat;
    logic [7:0]  s_sum_ed;
    logic [15:0] s_max_ed;
    logic [2:0]  s_err_count, s_sample_count;

    always #5 clk = ~clk;

    mul_error_accum #(.WIDTH(8), .SAMPLES(c_SAMPLES), .ACC_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(a_in_ready), .in1(in1), .in2(in2), .approx_prod(approx_prod),
        .busy(a_busy), .done(a_done), .sum_ed(a_sum_ed), .sum_sat(a_sum_sat),
        .max_ed(a_max_ed), .err_count(a_err_count), .sample_count(a_sample_count)
    );

    mul_error_accum #(.WIDTH(8), .SAMPLES(c_SAMPLES), .ACC_W(8)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(s_in_ready), .in1(in1), .in2(in2), .approx_prod(approx_prod),
        .busy(s_busy), .done(s_done), .sum_ed(s_sum_ed), .sum_sat(s_sum_sat),
        .max_ed(s_max_ed), .err_count(s_err_count), .sample_count(s_sample_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    // Window model: a sample accepted at one edge reaches the statistics two
    // edges later; the window closes one edge after the pipeline has emptied.
    typedef struct { longint ed; int age; } pend_t;
    pend_t  pq[$];
    bit     m_live = 0;
    int     m_ph;
    longint m_sum_a, m_sum_s, m_max, m_err, m_cnt;
    bit     m_sat_a, m_sat_s;

    always @(posedge clk) begin : model
        bit     was_empty;
        longint ed;
        if (rst) begin
            m_live = 1; m_ph = c_IDLE; pq.delete();
            m_sum_a = 0; m_sum_s = 0; m_max = 0; m_err = 0; m_cnt = 0;
            m_sat_a = 0; m_sat_s = 0;
        end else if (m_live) begin
            was_empty = (pq.size() == 0);
            foreach (pq[i]) pq[i].age++;
            while (pq.size() > 0 && pq[0].age >= 2) begin
                ed = pq[0].ed;
                void'(pq.pop_front());
                if (m_sum_a + ed > 64'hFFFF_FFFF) begin m_sum_a = 64'hFFFF_FFFF; m_sat_a = 1; end
                else m_sum_a += ed;
                if (m_sum_s + ed > 255) begin m_sum_s = 255; m_sat_s = 1; end
                else m_sum_s += ed;
                if (ed > m_max) m_max = ed;
                if (ed != 0) m_err++;
            end
            case (m_ph)
                c_IDLE: if (start) begin
                    m_ph = c_RUN;
                    m_sum_a = 0; m_sum_s = 0; m_max = 0; m_err = 0; m_cnt = 0;
                    m_sat_a = 0; m_sat_s = 0;
                end
                c_RUN: if (in_valid) begin
                    ed = longint'(in1) * longint'(in2) - longint'(approx_prod);
                    if (ed < 0) ed = -ed;
                    pq.push_back('{ed: ed, age: 0});
                    m_cnt++;
                    if (m_cnt == c_SAMPLES) m_ph = c_DRAIN;
                end
                c_DRAIN: if (was_empty) m_ph = c_DONE;
                default: m_ph = c_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("a_in_ready", a_in_ready, m_ph == c_RUN);
            chk("a_busy", a_busy, m_ph == c_RUN || m_ph == c_DRAIN);
            chk("a_done", a_done, m_ph == c_DONE);
            chk("a_sum_ed", a_sum_ed, m_sum_a);
            chk("a_sum_sat", a_sum_sat, m_sat_a);
            chk("a_max_ed", a_max_ed, m_max);
            chk("a_err_count", a_err_count, m_err);
            chk("a_sample_count", a_sample_count, m_cnt);
            chk("s_in_ready", s_in_ready, m_ph == c_RUN);
            chk("s_done", s_done, m_ph == c_DONE);
            chk("s_sum_ed", s_sum_ed, m_sum_s);
            chk("s_sum_sat", s_sum_sat, m_sat_s);
            chk("s_max_ed", s_max_ed, m_max);
            chk("s_err_count", s_err_count, m_err);
            chk("s_sample_count", s_sample_count, m_cnt);
        end
    end

    // Applies one cycle of inputs and advances past the next rising edge.
    task automatic drive(input logic s, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] p);
        start = s; in_valid = v; in1 = a; in2 = b; approx_prod = p;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    endtask

    // Waits (bounded) for the done pulse; the following cycle optionally
    // carries a start, which must be ignored in DONE.
    task automatic wait_done(input string name, input logic start_in_done);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (a_done) begin seen = 1; break; end
        end
        chk(name, seen, 1);
        drive(start_in_done, 1'b0, 8'd0, 8'd0, 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle(); idle();
        rst = 1'b0;
        chk("reset_sample_count", a_sample_count, 0);
        chk("reset_in_ready", a_in_ready, 0);

        // Exact window
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 8'd3, 8'd5, 16'd15);
        wait_done("t1_done", 1'b0);
        chk("t1_sum_ed", a_sum_ed, 0);
        chk("t1_err_count", a_err_count, 0);
        chk("t1_max_ed", a_max_ed, 0);
        chk("t1_sample_count", a_sample_count, 4);
        chk("t1_sum_sat", a_sum_sat, 0);

        // Error statistics; start in DONE must be ignored
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 8'd255, 8'd255, 16'd65000);
        drive(0, 1, 8'd255, 8'd255, 16'd65030);
        drive(0, 1, 8'd2, 8'd3, 16'd6);
        drive(0, 1, 8'd10, 8'd10, 16'd99);
        wait_done("t2_done", 1'b1);
        idle();
        chk("t2_sum_ed", a_sum_ed, 31);
        chk("t2_max_ed", a_max_ed, 25);
        chk("t2_err_count", a_err_count, 3);
        chk("t2_sample_count", a_sample_count, 4);
        chk("t2_in_ready_idle", a_in_ready, 0);

        // Handshake with bubbles; fifth valid must not be consumed
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 8'd1, 8'd2, 16'd2);
        drive(0, 0, 8'd9, 8'd9, 16'd0);
        drive(0, 1, 8'd4, 8'd4, 16'd16);
        drive(0, 1, 8'd5, 8'd5, 16'd20);
        drive(0, 0, 8'd9, 8'd9, 16'd0);
        drive(0, 1, 8'd6, 8'd6, 16'd36);
        chk("t3_ready_after_4th", a_in_ready, 0);
        drive(0, 1, 8'd200, 8'd200, 16'd0);
        wait_done("t3_done", 1'b0);
        chk("t3_sample_count", a_sample_count, 4);
        chk("t3_sum_ed", a_sum_ed, 5);
        chk("t3_max_ed", a_max_ed, 5);

        // Reset mid-window
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 8'd2, 8'd2, 16'd11);
        drive(0, 1, 8'd2, 8'd2, 16'd11);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("t4_sample_count", a_sample_count, 0);
        chk("t4_sum_ed", a_sum_ed, 0);
        chk("t4_busy", a_busy, 0);
        chk("t4_in_ready", a_in_ready, 0);
        idle(); idle();
        chk("t4_sum_ed_late", a_sum_ed, 0);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 8'd1, 8'd1, 16'd0);
        wait_done("t4_done", 1'b0);
        chk("t4_clean_sum", a_sum_ed, 4);
        chk("t4_clean_err", a_err_count, 4);

        // Saturation on the 8-bit accumulator instance
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 8'd10, 8'd20, 16'd0);
        drive(0, 1, 8'd10, 8'd10, 16'd0);
        drive(0, 1, 8'd1, 8'd1, 16'd1);
        drive(0, 1, 8'd0, 8'd0, 16'd0);
        wait_done("t5_done", 1'b0);
        chk("t5_s_sum_ed", s_sum_ed, 255);
        chk("t5_s_sum_sat", s_sum_sat, 1);
        chk("t5_s_max_ed", s_max_ed, 200);
        chk("t5_s_err_count", s_err_count, 2);
        chk("t5_a_sum_ed", a_sum_ed, 300);
        chk("t5_a_sum_sat", a_sum_sat, 0);

        // Start with in_valid in IDLE, then start during RUN
        drive(1, 1, 8'd7, 8'd7, 16'd0);
        chk("t6_no_accept_on_start", a_sample_count, 0);
        drive(0, 1, 8'd3, 8'd3, 16'd8);
        drive(1, 1, 8'd3, 8'd3, 16'd8);
        chk("t6_start_in_run", a_sample_count, 2);
        drive(0, 1, 8'd3, 8'd3, 16'd9);
        drive(0, 1, 8'd3, 8'd3, 16'd9);
        wait_done("t6_done", 1'b0);
        chk("t6_sample_count", a_sample_count, 4);
        chk("t6_sum_ed", a_sum_ed, 2);
        chk("t6_err_count", a_err_count, 2);
        idle(); idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
